// File: rtl/tmds_pkg.sv
// Shared TMDS constants: control tokens, counter width default, popcount.
package tmds_pkg;

    localparam int CNT_W_DEF = 6;

    localparam logic [9:0] CTL_00 = 10'b1101010100;
    localparam logic [9:0] CTL_01 = 10'b0010101011;
    localparam logic [9:0] CTL_10 = 10'b0101010100;
    localparam logic [9:0] CTL_11 = 10'b1010101011;

    function automatic logic [3:0] popcnt8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: stage 1 transition minimise, stage 2 DC balance.
// Optional sticky disparity monitor under TMDS_DISP_MON_EN.
module tmds_channel_enc
    import tmds_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_d,
    input  logic       i_de,
    input  logic [1:0] i_c,
    output logic [9:0] o_tmds,
    output logic       o_err
);

    localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

    logic [3:0] w_n1;
    logic       w_xnor;
    logic [8:0] w_qm;

    logic [8:0] r_qm;
    logic       r_de;
    logic [1:0] r_c;

    always_comb begin
        logic [8:0] v;
        w_n1   = popcnt8(i_d);
        w_xnor = (w_n1 > 4'd4) ||
                 ((w_n1 == 4'd4) && !i_d[0]);
        v      = '0;
        v[0]   = i_d[0];
        for (int i = 1; i < 8; i++) begin
            v[i] = w_xnor ? ~(v[i-1] ^ i_d[i])
                          :  (v[i-1] ^ i_d[i]);
        end
        v[8]   = ~w_xnor;
        w_qm   = v;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_qm <= '0;
            r_de <= 1'b0;
            r_c  <= 2'b00;
        end else begin
            r_qm <= w_qm;
            r_de <= i_de;
            r_c  <= i_c;
        end
    end

    logic [3:0]              w_n1q;
    logic signed [CNT_W-1:0] w_bal;
    logic signed [CNT_W-1:0] w_two;
    logic signed [CNT_W-1:0] w_twon;
    logic signed [CNT_W-1:0] w_cnt_nxt;
    logic [9:0]              w_word;
    logic [9:0]              w_tok;
    logic                    w_pos;
    logic                    w_neg;
    logic                    w_case_a;
    logic                    w_case_b;

    logic signed [CNT_W-1:0] r_cnt;
    logic [9:0]              r_out;

    // w_bal is N1q - N0q = 2*N1q - 8
    assign w_n1q  = popcnt8(r_qm[7:0]);
    assign w_bal  = $signed(CNT_W'({w_n1q, 1'b0}))
                  - $signed(CNT_W'(8));
    assign w_two  = r_qm[8] ? TWO : '0;
    assign w_twon = r_qm[8] ? '0 : TWO;
    assign w_neg  = r_cnt[CNT_W-1];
    assign w_pos  = !w_neg && (r_cnt != '0);

    assign w_case_a = (r_cnt == '0) || (w_n1q == 4'd4);
    assign w_case_b = !w_case_a &&
                      ((w_pos && (w_n1q > 4'd4)) ||
                       (w_neg && (w_n1q < 4'd4)));

    always_comb begin
        w_word    = '0;
        w_cnt_nxt = r_cnt;
        unique case (1'b1)
            w_case_a: begin
                w_word = {~r_qm[8], r_qm[8],
                          r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
                w_cnt_nxt = r_qm[8] ? r_cnt + w_bal
                                    : r_cnt - w_bal;
            end
            w_case_b: begin
                w_word    = {1'b1, r_qm[8], ~r_qm[7:0]};
                w_cnt_nxt = r_cnt + w_two - w_bal;
            end
            default: begin
                w_word    = {1'b0, r_qm[8], r_qm[7:0]};
                w_cnt_nxt = r_cnt + w_bal - w_twon;
            end
        endcase
    end

    always_comb begin
        w_tok = CTL_00;
        unique case (r_c)
            2'b00:   w_tok = CTL_00;
            2'b01:   w_tok = CTL_01;
            2'b10:   w_tok = CTL_10;
            default: w_tok = CTL_11;
        endcase
    end

    // blanking always restarts the disparity from zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out <= CTL_00;
            r_cnt <= '0;
        end else if (!r_de) begin
            r_out <= w_tok;
            r_cnt <= '0;
        end else begin
            r_out <= w_word;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_tmds = r_out;

`ifdef TMDS_DISP_MON_EN
    localparam logic signed [CNT_W-1:0] LIM_P = CNT_W'(10);
    localparam logic signed [CNT_W-1:0] LIM_N = -LIM_P;

    logic r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (r_de &&
                     ((w_cnt_nxt > LIM_P) ||
                      (w_cnt_nxt < LIM_N))) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: rtl/tmds_encoder.sv
// Three-channel DVI/TMDS encoder, 2-cycle latency, pixel clock domain.
// Build with TMDS_DISP_MON_EN to enable the disparity monitor.
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       pixclk,
    input  logic       rst,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] TMDS_red,
    output logic [9:0] TMDS_green,
    output logic [9:0] TMDS_blue,
    output logic [2:0] disp_err
);

    logic w_err_r;
    logic w_err_g;
    logic w_err_b;

    tmds_channel_enc #(.CNT_W(CNT_W)) u_blue (
        .i_clk  (pixclk),
        .i_rst  (rst),
        .i_d    (blue),
        .i_de   (de),
        .i_c    ({vsync, hsync}),
        .o_tmds (TMDS_blue),
        .o_err  (w_err_b)
    );

    tmds_channel_enc #(.CNT_W(CNT_W)) u_green (
        .i_clk  (pixclk),
        .i_rst  (rst),
        .i_d    (green),
        .i_de   (de),
        .i_c    (2'b00),
        .o_tmds (TMDS_green),
        .o_err  (w_err_g)
    );

    tmds_channel_enc #(.CNT_W(CNT_W)) u_red (
        .i_clk  (pixclk),
        .i_rst  (rst),
        .i_d    (red),
        .i_de   (de),
        .i_c    (2'b00),
        .o_tmds (TMDS_red),
        .o_err  (w_err_r)
    );

    assign disp_err = {w_err_r, w_err_g, w_err_b};

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: behavioural TMDS model plus literal checks.
module tb_tmds_encoder;

    logic       pixclk;
    logic       rst;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       de;
    logic       hsync;
    logic       vsync;
    logic [9:0] TMDS_red;
    logic [9:0] TMDS_green;
    logic [9:0] TMDS_blue;
    logic [2:0] disp_err;

    tmds_encoder dut (
        .pixclk     (pixclk),
        .rst        (rst),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .de         (de),
        .hsync      (hsync),
        .vsync      (vsync),
        .TMDS_red   (TMDS_red),
        .TMDS_green (TMDS_green),
        .TMDS_blue  (TMDS_blue),
        .disp_err   (disp_err)
    );

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    int n_cmp = 0;
    int n_bad = 0;
    logic run = 1'b1;

    logic [9:0] tok [4];
    initial begin
        tok[0] = 10'b1101010100;
        tok[1] = 10'b0010101011;
        tok[2] = 10'b0101010100;
        tok[3] = 10'b1010101011;
    end

    task automatic chk(input string nm,
                       input logic [9:0] act,
                       input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h",
                     nm, $time, act, exp);
        end
    endtask

    // Encode one word straight from the 8b/10b rules.
    function automatic logic [9:0] enc(input logic [7:0] d,
                                       input int cin,
                                       output int cout);
        int n1, n1q, n0q, q8, par;
        logic xn;
        logic [7:0] q;
        logic [9:0] w;
        n1  = $countones(d);
        xn  = (n1 > 4) || (n1 == 4 && !d[0]);
        par = 0;
        for (int i = 0; i < 8; i++) begin
            par  = par ^ int'(d[i]);
            q[i] = (par ^ ((xn && (i % 2 == 1)) ? 1 : 0)) != 0;
        end
        q8  = xn ? 0 : 1;
        n1q = $countones(q);
        n0q = 8 - n1q;
        if (cin == 0 || n1q == n0q) begin
            w    = {q8 == 0, q8 == 1, (q8 == 1) ? q : ~q};
            cout = cin + ((q8 == 1) ? n1q - n0q : n0q - n1q);
        end else if ((cin > 0 && n1q > n0q) ||
                     (cin < 0 && n0q > n1q)) begin
            w    = {1'b1, q8 == 1, ~q};
            cout = cin + 2 * q8 + n0q - n1q;
        end else begin
            w    = {1'b0, q8 == 1, q};
            cout = cin + n1q - n0q - 2 * (1 - q8);
        end
        return w;
    endfunction

    int         mcnt [3];
    logic [9:0] pend [3];
    logic [9:0] expw [3];
    logic [2:0] err_acc;
    logic [2:0] exp_err;

    // Model: sample inputs at each rising edge, result shows next edge.
    initial begin
        forever begin
            @(posedge pixclk);
            if (rst) begin
                for (int k = 0; k < 3; k++) begin
                    mcnt[k] = 0;
                    pend[k] = tok[0];
                    expw[k] = tok[0];
                end
                err_acc = '0;
                exp_err = '0;
            end else begin
                logic [7:0] d [3];
                int c [3];
                d[0] = blue;
                d[1] = green;
                d[2] = red;
                c[0] = {30'd0, vsync, hsync};
                c[1] = 0;
                c[2] = 0;
                exp_err = err_acc;
                for (int k = 0; k < 3; k++) begin
                    expw[k] = pend[k];
                    if (de) begin
                        pend[k] = enc(d[k], mcnt[k], mcnt[k]);
`ifdef TMDS_DISP_MON_EN
                        if (mcnt[k] > 10 || mcnt[k] < -10)
                            err_acc[k] = 1'b1;
`endif
                    end else begin
                        pend[k] = tok[c[k]];
                        mcnt[k] = 0;
                    end
                end
            end
        end
    end

    // Compare every cycle against the model.
    initial begin
        forever begin
            @(negedge pixclk);
            if (run) begin
                if (rst) begin
                    chk("cmp_blue",  TMDS_blue,  tok[0]);
                    chk("cmp_green", TMDS_green, tok[0]);
                    chk("cmp_red",   TMDS_red,   tok[0]);
                    chk("cmp_err", {7'd0, disp_err}, 10'd0);
                end else begin
                    chk("cmp_blue",  TMDS_blue,  expw[0]);
                    chk("cmp_green", TMDS_green, expw[1]);
                    chk("cmp_red",   TMDS_red,   expw[2]);
                    chk("cmp_err", {7'd0, disp_err},
                        {7'd0, exp_err});
                end
            end
        end
    end

    typedef struct {
        logic       en;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } lit_t;

    lit_t litq [$];

    task automatic px(input logic [7:0] r, g, b,
                      input logic e, hs, vs,
                      input logic en,
                      input logic [9:0] er, eg, eb);
        lit_t t;
        red   = r;
        green = g;
        blue  = b;
        de    = e;
        hsync = hs;
        vsync = vs;
        t.en  = en;
        t.r   = er;
        t.g   = eg;
        t.b   = eb;
        litq.push_back(t);
        @(negedge pixclk);
        if (litq.size() == 2) begin
            t = litq.pop_front();
            if (t.en) begin
                chk("lit_red",   TMDS_red,   t.r);
                chk("lit_green", TMDS_green, t.g);
                chk("lit_blue",  TMDS_blue,  t.b);
            end
        end
    endtask

    task automatic blank();
        px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0,
           1'b1, 10'h354, 10'h354, 10'h354);
    endtask

    task automatic act3(input logic [7:0] v,
                        input logic [9:0] ew);
        px(v, v, v, 1'b1, 1'b0, 1'b0, 1'b1, ew, ew, ew);
    endtask

    initial begin
        rst   = 1'b1;
        red   = '0;
        green = '0;
        blue  = '0;
        de    = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        repeat (3) @(negedge pixclk);
        chk("rst_red", TMDS_red, 10'h354);
        chk("rst_err", {7'd0, disp_err}, 10'd0);
        rst = 1'b0;

        blank();
        blank();
        px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0,
           1'b1, 10'h354, 10'h354, 10'h354);
        px(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0,
           1'b1, 10'h354, 10'h354, 10'h0AB);
        px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1,
           1'b1, 10'h354, 10'h354, 10'h154);
        px(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1,
           1'b1, 10'h354, 10'h354, 10'h2AB);

        blank();
        act3(8'h00, 10'h100);
        act3(8'h00, 10'h3FF);
        act3(8'h00, 10'h100);

        blank();
        act3(8'hFF, 10'h200);

        blank();
        act3(8'h00, 10'h100);
        act3(8'h00, 10'h3FF);
        blank();
        act3(8'h00, 10'h100);

        // hsync/vsync must be ignored while de=1
        blank();
        px(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1,
           1'b1, 10'h100, 10'h100, 10'h100);
        blank();
        blank();

        for (int i = 0; i < 20; i++) begin
            px(8'($urandom), 8'($urandom), 8'($urandom),
               1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_red",   TMDS_red,   10'h354);
        chk("arst_green", TMDS_green, 10'h354);
        chk("arst_blue",  TMDS_blue,  10'h354);
        chk("arst_err", {7'd0, disp_err}, 10'd0);
        de = 1'b0;
        litq.delete();
        @(negedge pixclk);
        @(negedge pixclk);
        rst = 1'b0;
        blank();
        blank();
        blank();

        for (int i = 0; i < 10000; i++) begin
            logic e;
            e = ($urandom_range(0, 15) != 0);
            px(8'($urandom), 8'($urandom), 8'($urandom),
               e, 1'($urandom), 1'($urandom),
               1'b0, '0, '0, '0);
        end
        blank();
        blank();
        blank();

        run = 1'b0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
